alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, default 32, operand/result width (only 32 supported).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port: req_ready  output  2  per-requester accept, one-hot or zero.
REQ-006 SHALL have port: req0_data  input  alu_req_t  requester 0 operation bundle.
REQ-007 SHALL have port: req1_data  input  alu_req_t  requester 1 operation bundle.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: rsp_id  output  1  index of requester owning rsp_res.
REQ-011 SHALL have port: rsp_res  output  32  ALU result.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-014 IDLE: SHALL assert req_ready[g] combinationally for granted g when any req_valid bit is high; transfer = valid&ready in same cycle.
REQ-015 Grant: single valid -> that requester; both valid -> requester != last_grant (round-robin).
REQ-016 last_grant SHALL update to g on transfer only; reset value 1 (requester 0 wins first tie).
REQ-017 On transfer SHALL register granted bundle and g; next state EXEC.
REQ-018 EXEC: SHALL drive ALU_block solely from registered bundle; capture ALURes into rsp_res and g into rsp_id at clock edge; next state RESP.
REQ-019 RESP: SHALL hold rsp_valid=1 with rsp_res, rsp_id stable until rsp_valid&rsp_ready; then next state IDLE.
REQ-020 Latency: transfer in cycle N -> rsp_valid first high in cycle N+2; best-case throughput one operation per 3 cycles.
REQ-021 req_ready SHALL be 0 in EXEC and RESP; requests arriving then wait, with no loss and no reordering per requester.
REQ-022 Requester SHALL hold req_valid and data stable until accepted; arbiter samples data only in transfer cycle.
REQ-023 rsp_ready high in IDLE/EXEC SHALL have no effect.
REQ-024 Arithmetic, overflow, wrap and operand muxing (ALUASrc selects Pc, ALUBSrc selects ImmExt) SHALL be exactly those of ALU_block; no saturation or flags.
REQ-025 Registered operand and result contents SHALL not change outside transfer and EXEC edges.

Reset
REQ-026 While rst_n low: state IDLE, req_ready=0, rsp_valid=0, rsp_res=0, rsp_id=0, busy=0, last_grant=1, operand registers 0.
REQ-027 Reset asserted in EXEC or RESP SHALL discard the operation; no response after deassertion.
REQ-028 First transfer possible in first clock edge after rst_n deasserts.

Structure
REQ-029 Package alu_arb_pkg SHALL hold alu_req_t (packed: ALUOp[3:0], ALUASrc, ALUBSrc, RUrs1, RUrs2, ImmExt, Pc, each 32 bits), state enum arb_state_t, and NUM_REQ=2.
REQ-030 SHALL instantiate exactly one ALU_block sub-module; no other sub-modules.

Verification
REQ-031 Reset then req_valid=01, ALUOp=0000 (ADD), RUrs1=5, RUrs2=7, srcs 0 -> req_ready=01 same cycle, rsp_valid at N+2, rsp_res=12, rsp_id=0.
REQ-032 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 with req0 first; rsp_id sequence matches.
REQ-033 ALUASrc=1, Pc=0x1000, ALUBSrc=1, ImmExt=0xFFFFFFFC, ADD -> rsp_res=0x00000FFC.
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_res, rsp_id stable, req_ready=00, busy=1; release -> IDLE next cycle.
REQ-035 rst_n low during EXEC -> all outputs at reset values asynchronously; no rsp_valid after release without new request.
REQ-036 RUrs1=0xFFFFFFFF, RUrs2=1, ADD -> rsp_res=0x00000000 (wrap).

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types for the two-requester ALU arbiter: operation bundle, FSM states
// and ALU operation encodings.
package alu_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;

  typedef struct packed {
    logic [3:0]      ALUOp;
    logic            ALUASrc;
    logic            ALUBSrc;
    logic [XLEN-1:0] RUrs1;
    logic [XLEN-1:0] RUrs2;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] Pc;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // ALUOp encodings; bit 3 selects the subtract/arithmetic variant
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

endpackage

// File: rtl/ALU_block.sv
// Combinational 32-bit ALU with operand source muxing (Pc for A, ImmExt for B).
module ALU_block
  import alu_arb_pkg::*;
(
  input  logic [3:0]      ALUOp,
  input  logic            ALUASrc,
  input  logic            ALUBSrc,
  input  logic [XLEN-1:0] RUrs1,
  input  logic [XLEN-1:0] RUrs2,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] Pc,
  output logic [XLEN-1:0] ALURes
);

  logic [XLEN-1:0] a_s;
  logic [XLEN-1:0] b_s;

  // Operand selection and operation decode; arithmetic wraps modulo 2^32
  always_comb begin
    a_s    = ALUASrc ? Pc : RUrs1;
    b_s    = ALUBSrc ? ImmExt : RUrs2;
    ALURes = 32'd0;
    case (ALUOp)
      ALU_ADD:   ALURes = a_s + b_s;
      ALU_SUB:   ALURes = a_s - b_s;
      ALU_SLL:   ALURes = a_s << b_s[4:0];
      ALU_SLT:   ALURes = {31'd0, ($signed(a_s) < $signed(b_s))};
      ALU_SLTU:  ALURes = {31'd0, (a_s < b_s)};
      ALU_XOR:   ALURes = a_s ^ b_s;
      ALU_SRL:   ALURes = a_s >> b_s[4:0];
      ALU_SRA:   ALURes = $unsigned($signed(a_s) >>> b_s[4:0]);
      ALU_OR:    ALURes = a_s | b_s;
      ALU_AND:   ALURes = a_s & b_s;
      ALU_PASSB: ALURes = b_s;
      default:   ALURes = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters through an
// IDLE -> EXEC -> RESP handshake FSM.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  alu_req_t           req0_data,
  input  alu_req_t           req1_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_res,
  output logic               busy
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  alu_req_t          op_q, op_d;
  logic              gid_q, gid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;

  logic              grant_s;
  logic              transfer_s;
  logic [XLEN-1:0]   alu_res_s;

  // Grant selection and combinational accept; gated by rst_n so nothing is accepted in reset
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
    transfer_s = (req_valid & req_ready) != 2'b00;
  end

  ALU_block u_alu (
    .ALUOp   (op_q.ALUOp),
    .ALUASrc (op_q.ALUASrc),
    .ALUBSrc (op_q.ALUBSrc),
    .RUrs1   (op_q.RUrs1),
    .RUrs2   (op_q.RUrs2),
    .ImmExt  (op_q.ImmExt),
    .Pc      (op_q.Pc),
    .ALURes  (alu_res_s)
  );

  // Next-state logic; operand and result registers only move on transfer and EXEC
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    gid_d        = gid_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    case (state_q)
      IDLE: begin
        if (transfer_s) begin
          state_d      = EXEC;
          last_grant_d = grant_s;
          gid_d        = grant_s;
          op_d         = grant_s ? req1_data : req0_data;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_res_d = alu_res_s;
        rsp_id_d  = gid_q;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      gid_q        <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      gid_q        <= gid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;

endmodule
